display_data_latch: RTL and testbench

Frame-synchronous holding stage directly upstream of `vga_writer`. Accepts robot location, move command, target and orientation updates from the planning and ultrasound logic at arbitrary times. Commits them to `vga_writer`'s inputs only at a frame boundary, so one displayed frame never mixes old and new data. Also reports overwritten updates and flags a stale feed.

---
 rtl/display_data_latch_pkg.sv | 27 ++
 rtl/display_data_latch_frame_tick.sv | 23 ++
 rtl/display_data_latch.sv | 138 +++++++++++++
 tb/tb_display_data_latch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_data_latch_pkg.sv
// Shared field widths and state encoding for the display data latch and its
// downstream VGA writer.
package display_data_latch_pkg;

  localparam int LOC_W    = 12;
  localparam int MOVE_W   = 12;
  localparam int ORIENT_W = 4;
  localparam int TARGET_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } latch_state_t;

  // Location, move command and target always travel as one word.
  typedef struct packed {
    logic [LOC_W-1:0]    location;
    logic [MOVE_W-1:0]   move_command;
    logic [TARGET_W-1:0] target_location;
  } data_word_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/display_data_latch_frame_tick.sv
// One-cycle frame tick on the first clock that sees active-low vsync asserted.
// Shared by the frame-synchronous display blocks.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic frame_tick
);

  logic vsync_q;

  // Idle level of vsync is high, so reset there to avoid a spurious tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync;
    end
  end

  assign frame_tick = vsync_q & ~vsync;

endmodule

// File: rtl/display_data_latch.sv
// Holds planner/ultrasound updates in shadow registers and commits them to the
// VGA writer inputs only on a frame tick, so a frame never mixes old and new data.
module display_data_latch
  import display_data_latch_pkg::*;
#(
  parameter int STALE_FRAMES = 60
) (
  input  logic                vclock,
  input  logic                reset,
  input  logic                vsync,
  input  logic [LOC_W-1:0]    in_location,
  input  logic [MOVE_W-1:0]   in_move_command,
  input  logic [TARGET_W-1:0] in_target_location,
  input  logic                in_data_valid,
  output logic                in_data_ready,
  input  logic [ORIENT_W-1:0] in_orientation,
  input  logic                in_orientation_valid,
  output logic [LOC_W-1:0]    location,
  output logic [MOVE_W-1:0]   move_command,
  output logic [TARGET_W-1:0] target_location,
  output logic [ORIENT_W-1:0] orientation,
  output logic                new_data,
  output logic                orientation_ready,
  output logic                stale,
  output logic [7:0]          drop_count
);

  localparam logic [7:0] STALE_MAX = 8'(STALE_FRAMES);

  latch_state_t        state;
  data_word_t          shadow;
  data_word_t          in_word;
  data_word_t          eff_word;
  logic [ORIENT_W-1:0] orient_shadow;
  logic                orient_pend;
  logic [7:0]          stale_cnt;
  logic [7:0]          stale_cnt_nxt;
  logic                frame_tick;
  logic                tick;
  logic                xfer;
  logic                commit_data;
  logic                commit_any;

  frame_tick_gen u_frame_tick (
    .clk        (vclock),
    .rst        (reset),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  assign in_data_ready = (state != COMMIT);
  assign xfer          = in_data_valid & in_data_ready;
  // A tick landing in the COMMIT cycle cannot come from a legal vsync; drop it.
  assign tick          = frame_tick & (state != COMMIT);

  assign in_word.location        = in_location;
  assign in_word.move_command    = in_move_command;
  assign in_word.target_location = in_target_location;

  // A word arriving on the commit edge wins over the shadow.
  assign eff_word    = xfer ? in_word : shadow;
  assign commit_data = tick & (xfer | (state == PENDING));
  assign commit_any  = commit_data | (tick & orient_pend);

  always_comb begin
    stale_cnt_nxt = stale_cnt;
    if (commit_data) begin
      stale_cnt_nxt = 8'd0;
    end else if (tick && (stale_cnt != STALE_MAX)) begin
      stale_cnt_nxt = stale_cnt + 8'd1;
    end
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      shadow            <= '0;
      orient_shadow     <= '0;
      orient_pend       <= 1'b0;
      location          <= '0;
      move_command      <= '0;
      target_location   <= '0;
      orientation       <= '0;
      new_data          <= 1'b0;
      orientation_ready <= 1'b0;
      drop_count        <= 8'd0;
      stale_cnt         <= STALE_MAX;
      stale             <= 1'b1;
    end else begin
      new_data  <= commit_data;
      stale_cnt <= stale_cnt_nxt;
      stale     <= (stale_cnt_nxt == STALE_MAX);

      if (xfer) begin
        shadow <= in_word;
      end
      if (xfer && (state == PENDING)) begin
        drop_count <= sat_inc8(drop_count);
      end

      if (commit_data) begin
        location        <= eff_word.location;
        move_command    <= eff_word.move_command;
        target_location <= eff_word.target_location;
      end
      if (commit_any && orient_pend) begin
        orientation       <= orient_shadow;
        orientation_ready <= 1'b1;
      end

      // A strobe on the commit edge is kept pending for the next frame.
      if (in_orientation_valid) begin
        orient_shadow <= in_orientation;
        orient_pend   <= 1'b1;
      end else if (commit_any) begin
        orient_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (commit_any) begin
            state <= COMMIT;
          end else if (xfer) begin
            state <= PENDING;
          end
        end
        PENDING: begin
          if (commit_any) begin
            state <= COMMIT;
          end
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_data_latch.sv
// Directed and randomized bench for display_data_latch, checked against a
// frame-level reference model of the latch behaviour.
module tb_display_data_latch;

  localparam int STALE = 3;

  logic        vclock;
  logic        reset;
  logic        vsync;
  logic [11:0] in_location;
  logic [11:0] in_move_command;
  logic [3:0]  in_target_location;
  logic        in_data_valid;
  logic        in_data_ready;
  logic [3:0]  in_orientation;
  logic        in_orientation_valid;
  logic [11:0] location;
  logic [11:0] move_command;
  logic [3:0]  target_location;
  logic [3:0]  orientation;
  logic        new_data;
  logic        orientation_ready;
  logic        stale;
  logic [7:0]  drop_count;

  int checks;
  int errors;

  display_data_latch #(.STALE_FRAMES(STALE)) dut (
    .vclock               (vclock),
    .reset                (reset),
    .vsync                (vsync),
    .in_location          (in_location),
    .in_move_command      (in_move_command),
    .in_target_location   (in_target_location),
    .in_data_valid        (in_data_valid),
    .in_data_ready        (in_data_ready),
    .in_orientation       (in_orientation),
    .in_orientation_valid (in_orientation_valid),
    .location             (location),
    .move_command         (move_command),
    .target_location      (target_location),
    .orientation          (orientation),
    .new_data             (new_data),
    .orientation_ready    (orientation_ready),
    .stale                (stale),
    .drop_count           (drop_count)
  );

  initial vclock = 1'b0;
  always #5 vclock = ~vclock;

  // Reference model: what the display side should see, tracked per edge.
  bit          m_vs_prev, m_busy, m_have, m_opend, m_ordy, m_new;
  logic [11:0] m_sloc, m_smv, m_loc, m_mv;
  logic [3:0]  m_stg, m_tg, m_osh, m_ori;
  int          m_drop, m_frames_since;

  task automatic m_reset();
    m_vs_prev = 1; m_busy = 0; m_have = 0; m_opend = 0; m_ordy = 0; m_new = 0;
    m_sloc = 0; m_smv = 0; m_stg = 0; m_osh = 0;
    m_loc = 0; m_mv = 0; m_tg = 0; m_ori = 0;
    m_drop = 0; m_frames_since = STALE;
  endtask

  task automatic m_step();
    bit tick, xfer, cd, ca;
    tick = m_vs_prev && !vsync && !m_busy;
    xfer = in_data_valid && !m_busy;
    cd   = tick && (xfer || m_have);
    ca   = cd || (tick && m_opend);
    if (xfer && m_have) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    if (cd) begin
      m_loc = xfer ? in_location        : m_sloc;
      m_mv  = xfer ? in_move_command    : m_smv;
      m_tg  = xfer ? in_target_location : m_stg;
      m_have = 0;
      m_frames_since = 0;
    end else begin
      if (xfer) begin
        m_have = 1; m_sloc = in_location; m_smv = in_move_command; m_stg = in_target_location;
      end
      if (tick && m_frames_since < STALE) m_frames_since++;
    end
    if (ca && m_opend) begin
      m_ori = m_osh; m_ordy = 1;
    end
    if (in_orientation_valid) begin
      m_osh = in_orientation; m_opend = 1;
    end else if (ca) begin
      m_opend = 0;
    end
    m_new = cd;
    m_busy = ca;
    m_vs_prev = vsync;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("location", 32'(location), 32'(m_loc));
    chk("move_command", 32'(move_command), 32'(m_mv));
    chk("target_location", 32'(target_location), 32'(m_tg));
    chk("orientation", 32'(orientation), 32'(m_ori));
    chk("new_data", 32'(new_data), 32'(m_new));
    chk("orientation_ready", 32'(orientation_ready), 32'(m_ordy));
    chk("stale", 32'(stale), 32'(m_frames_since >= STALE));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("in_data_ready", 32'(in_data_ready), 32'(!m_busy));
  endtask

  task automatic cycle();
    m_step();
    @(posedge vclock);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic offer(input logic [11:0] l, input logic [11:0] m, input logic [3:0] t);
    in_data_valid = 1; in_location = l; in_move_command = m; in_target_location = t;
    cycle();
    in_data_valid = 0;
  endtask

  task automatic vsync_fall();
    vsync = 0;
    cycle();
  endtask

  task automatic vsync_rest();
    cycle();
    vsync = 1;
    idle(4);
  endtask

  initial begin
    int vs_left;
    bit acc;
    checks = 0; errors = 0;
    vsync = 1; in_data_valid = 0; in_orientation_valid = 0;
    in_location = 0; in_move_command = 0; in_target_location = 0; in_orientation = 0;

    // Reset
    reset = 1;
    #100;
    reset = 0;
    m_reset();
    check_all();
    chk("rst_ready", 32'(in_data_ready), 32'd1);
    chk("rst_stale", 32'(stale), 32'd1);
    chk("rst_loc", 32'(location), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    // Basic commit
    idle(3);
    offer(12'h3A5, 12'h5A5, 4'h7);
    idle(4);
    chk("hold_loc", 32'(location), 32'd0);
    vsync_fall();
    chk("basic_loc", 32'(location), 32'h3A5);
    chk("basic_new", 32'(new_data), 32'd1);
    chk("basic_rdy_low", 32'(in_data_ready), 32'd0);
    chk("basic_stale", 32'(stale), 32'd0);
    cycle();
    chk("basic_new_end", 32'(new_data), 32'd0);
    chk("basic_rdy_back", 32'(in_data_ready), 32'd1);
    vsync = 1;
    idle(4);

    // Overwrite within one frame
    offer(12'h111, 12'h011, 4'h1);
    offer(12'h222, 12'h022, 4'h2);
    idle(2);
    vsync_fall();
    chk("ovw_loc", 32'(location), 32'h222);
    chk("ovw_drop", 32'(drop_count), 32'd1);
    vsync_rest();

    // Offer on the tick edge from IDLE
    in_data_valid = 1; in_location = 12'h0F0; in_move_command = 12'hABC; in_target_location = 4'h9;
    vsync = 0;
    cycle();
    in_data_valid = 0;
    chk("simul_loc", 32'(location), 32'h0F0);
    chk("simul_new", 32'(new_data), 32'd1);
    chk("simul_drop", 32'(drop_count), 32'd1);
    vsync_rest();

    // Orientation only
    in_orientation = 4'h6; in_orientation_valid = 1;
    cycle();
    in_orientation_valid = 0;
    idle(2);
    vsync_fall();
    chk("ori_val", 32'(orientation), 32'h6);
    chk("ori_ready", 32'(orientation_ready), 32'd1);
    chk("ori_new", 32'(new_data), 32'd0);
    chk("ori_stale", 32'(stale), 32'd0);
    vsync_rest();

    // Staleness
    for (int f = 0; f < 3; f++) begin
      vsync_fall();
      vsync_rest();
    end
    chk("stale_set", 32'(stale), 32'd1);
    offer(12'h456, 12'h789, 4'h3);
    vsync_fall();
    chk("stale_clr", 32'(stale), 32'd0);
    vsync_rest();

    // Randomized traffic with held offers and random frame timing
    vs_left = 6;
    for (int i = 0; i < 1500; i++) begin
      if (!in_data_valid && $urandom_range(0, 3) == 0) begin
        in_data_valid = 1;
        in_location = 12'($urandom);
        in_move_command = 12'($urandom);
        in_target_location = 4'($urandom);
      end
      in_orientation_valid = ($urandom_range(0, 15) == 0);
      in_orientation = 4'($urandom);
      vs_left--;
      if (vs_left == 0) begin
        vsync = ~vsync;
        vs_left = vsync ? int'($urandom_range(4, 20)) : int'($urandom_range(1, 4));
      end
      acc = in_data_valid && !m_busy;
      cycle();
      if (acc) in_data_valid = 0;
    end
    in_data_valid = 0; in_orientation_valid = 0;
    vsync = 1;
    idle(4);

    // Repeated overwrites saturate the drop counter
    for (int i = 0; i < 300; i++) begin
      offer(12'(i), 12'(i + 1), 4'(i));
      offer(12'(i + 7), 12'(i + 8), 4'(i + 1));
      vsync_fall();
      vsync_rest();
    end
    chk("drop_sat", 32'(drop_count), 32'd255);

    // Reset asserted during COMMIT
    offer(12'h777, 12'h333, 4'h5);
    vsync_fall();
    chk("pre_rst_new", 32'(new_data), 32'd1);
    reset = 1;
    vsync = 1;
    #1;
    chk("rst_mid_new", 32'(new_data), 32'd0);
    chk("rst_mid_loc", 32'(location), 32'd0);
    chk("rst_mid_rdy", 32'(in_data_ready), 32'd1);
    chk("rst_mid_drop", 32'(drop_count), 32'd0);
    #100;
    reset = 0;
    m_reset();
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
